// File: rtl/fetch_unit_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared constants and state encoding for the instruction fetch stage.
// Revision    : 1.0  initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int          INSTR_W = 32;
    localparam int          PC_STEP = 4;
    localparam logic [31:0] HLT_OP  = 32'hD440_0000;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Fetch-stage bus bundle: imem request/response, redirect, decoder side.
// Revision    : 1.0  initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int ADDR_W = 64
);
    import fetch_unit_pkg::*;

    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [ADDR_W-1:0]   imem_req_addr;
    logic                imem_rsp_valid;
    logic [INSTR_W-1:0]  imem_rsp_data;
    logic                redirect_valid;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                req_halt;
    logic                inst_valid;
    logic                inst_ready;
    logic [INSTR_W-1:0]  instruction;
    logic [ADDR_W-1:0]   inst_pc;
    logic                halted;
    logic [31:0]         perf_fetched;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
               halted, perf_fetched,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid,
               redirect_pc, req_halt, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
               halted, perf_fetched,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid,
               redirect_pc, req_halt, inst_ready
    );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_unit_fifo
// Description : Synchronous FIFO with flush; head reads as zero while empty.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_unit_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_push,
    input  wire logic                   i_pop,
    input  wire logic                   i_flush,
    input  wire logic [WIDTH-1:0]       i_wdata,
    output logic      [WIDTH-1:0]       o_rdata,
    output logic                        o_full,
    output logic                        o_empty,
    output logic      [$clog2(DEPTH):0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == (PTR_W+1)'(DEPTH));
    assign o_count  = r_count;
    assign o_rdata  = o_empty ? '0 : r_mem[r_rdPtr];
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            r_count <= r_count + (PTR_W+1)'(w_doPush) - (PTR_W+1)'(w_doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush && !rst && !i_flush) r_mem[r_wrPtr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage: PC, fetch credits, stale-response discard,
//               in-order buffer and RUN/HALT control. Optional FETCH_PERF_EN
//               builds the delivered-instruction counter.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire logic   clk,
    input  wire logic   rst,
    fetch_unit_if.master bus
);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_rspPc;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_discard;
    logic [CNT_W-1:0]  w_outstandingNext;
    logic [CNT_W-1:0]  w_count;
    logic [ENTRY_W-1:0] w_head;
    logic              w_run;
    logic              w_redirect;
    logic              w_issue;
    logic              w_rspKeep;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_target;

    assign w_run      = (r_state == ST_RUN);
    assign w_redirect = bus.redirect_valid && w_run;
    assign w_target   = bus.redirect_pc & ~ADDR_W'(3);

    // Credits cover both in-flight fetches and buffered words, so the buffer never overflows.
    assign bus.imem_req_valid = !rst && w_run && !w_redirect &&
                                (({1'b0, r_outstanding} + {1'b0, w_count}) < (CNT_W+1)'(DEPTH));
    assign bus.imem_req_addr  = r_pc;
    assign w_issue            = bus.imem_req_valid && bus.imem_req_ready;

    assign w_rspKeep = bus.imem_rsp_valid && w_run && (r_discard == '0) && !w_redirect;
    assign w_pop     = bus.inst_valid && bus.inst_ready;
    assign w_push    = w_rspKeep && (!w_full || w_pop);

    always_comb begin
        w_outstandingNext = r_outstanding;
        if (w_issue) w_outstandingNext = w_outstandingNext + CNT_W'(1);
        if (bus.imem_rsp_valid && r_outstanding != '0)
            w_outstandingNext = w_outstandingNext - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_rspPc       <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_outstandingNext;
            if (w_redirect) begin
                // Everything still in flight belongs to the abandoned path.
                r_pc      <= w_target;
                r_rspPc   <= w_target;
                r_discard <= w_outstandingNext;
            end else begin
                if (w_issue)  r_pc    <= r_pc + ADDR_W'(PC_STEP);
                if (w_push)   r_rspPc <= r_rspPc + ADDR_W'(PC_STEP);
                if (bus.imem_rsp_valid && r_discard != '0)
                    r_discard <= r_discard - CNT_W'(1);
                if (w_pop && bus.req_halt)
                    r_state <= ST_HALT;
            end
        end
    end

    fetch_unit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .i_wdata ({r_rspPc, bus.imem_rsp_data}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.inst_valid  = !w_empty && w_run;
    assign bus.instruction = w_head[INSTR_W-1:0];
    assign bus.inst_pc     = w_head[ENTRY_W-1:INSTR_W];
    assign bus.halted      = (r_state == ST_HALT);

`ifdef FETCH_PERF_EN
    logic [31:0] r_perfFetched;

    always_ff @(posedge clk) begin
        if (rst)        r_perfFetched <= '0;
        else if (w_pop) r_perfFetched <= r_perfFetched + 32'd1;
    end

    assign bus.perf_fetched = r_perfFetched;
`else
    assign bus.perf_fetched = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench: cycle table, scoreboard, redirect/halt/perf sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int c_ADDR_W = 64;
    localparam int c_DEPTH  = 2;

    typedef struct { logic [31:0] instr; logic [63:0] pc; } exp_t;
    typedef struct { int due; logic [63:0] addr; } mem_t;
    typedef struct { logic reqV; logic [63:0] reqAddr; logic instV; logic [63:0] instPc; } row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(c_ADDR_W)) bus ();

    fetch_unit #(
        .ADDR_W   (c_ADDR_W),
        .DEPTH    (c_DEPTH),
        .RESET_PC (64'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          memLat = 1;
    int          popCount = 0;
    exp_t        sb[$];
    mem_t        memQ[$];
    logic [63:0] expPc = '0;
    logic        expHalted = 1'b0;
    logic [63:0] hltAddr = '1;
    logic        autoHalt = 1'b0;
    logic        redirectOnHlt = 1'b0;
    logic [63:0] hltRedirect = '0;
    logic        sReqV, sInstV, lastPop, lastRedir;
    logic [63:0] sReqAddr, sInstPc, lastPopPc;
    logic [31:0] sInstr, lastPopInstr;
    row_t        rows[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [63:0] a);
        if (a == hltAddr) return HLT_OP;
        return {4'hA, a[27:0]};
    endfunction

    // One clock cycle: called at a negedge, returns at the next negedge.
    task automatic tick();
        exp_t e;
        logic haltNow;
        haltNow   = 1'b0;
        lastPop   = 1'b0;
        lastRedir = 1'b0;
        if (memQ.size() > 0 && memQ[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memWord(memQ[0].addr);
            memQ.delete(0);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
        #1;
        if (autoHalt) bus.req_halt = bus.inst_valid && (bus.instruction == HLT_OP);
        if (redirectOnHlt && bus.req_halt) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = hltRedirect;
            redirectOnHlt      = 1'b0;
        end
        #1;
        sReqV    = bus.imem_req_valid;
        sReqAddr = bus.imem_req_addr;
        sInstV   = bus.inst_valid;
        sInstPc  = bus.inst_pc;
        sInstr   = bus.instruction;
        check("halted", bus.halted, expHalted);
        if (expHalted) begin
            check("halt_req_valid", sReqV, 1'b0);
            check("halt_inst_valid", sInstV, 1'b0);
        end
        if (sReqV && bus.imem_req_ready) begin
            check("req_addr", sReqAddr, expPc);
            sb.push_back('{memWord(expPc), expPc});
            memQ.push_back('{cyc + memLat, sReqAddr});
            expPc = expPc + 64'd4;
        end
        if (sInstV && bus.inst_ready) begin
            popCount++;
            lastPop      = 1'b1;
            lastPopPc    = sInstPc;
            lastPopInstr = sInstr;
            check("pop_expected", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("instruction", sInstr, e.instr);
                check("inst_pc", sInstPc, e.pc);
            end
            if (bus.req_halt && !bus.redirect_valid) haltNow = 1'b1;
        end
        if (bus.redirect_valid && !expHalted) begin
            lastRedir = 1'b1;
            check("redirect_no_req", sReqV, 1'b0);
            sb.delete();
            expPc = bus.redirect_pc & ~64'h3;
        end
        @(posedge clk);
        cyc++;
        if (haltNow) expHalted = 1'b1;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic waitPop(input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            tick();
            if (lastPop) break;
        end
        check("wait_pop_timeout", lastPop, 1'b1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.req_halt       = 1'b0;
        bus.inst_ready     = 1'b1;
        memQ.delete();
        sb.delete();
        expPc = 64'h0; expHalted = 1'b0; autoHalt = 1'b0; redirectOnHlt = 1'b0;
        hltAddr = '1; popCount = 0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rst_req_valid", bus.imem_req_valid, 1'b0);
        check("rst_inst_valid", bus.inst_valid, 1'b0);
        check("rst_instruction", bus.instruction, 32'h0);
        check("rst_inst_pc", bus.inst_pc, 64'h0);
        check("rst_halted", bus.halted, 1'b0);
        check("rst_perf", bus.perf_fetched, 32'h0);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rows[0] = '{1'b1, 64'h0,  1'b0, 64'h0};
        rows[1] = '{1'b1, 64'h4,  1'b0, 64'h0};
        rows[2] = '{1'b0, 64'h8,  1'b1, 64'h0};
        rows[3] = '{1'b1, 64'h8,  1'b1, 64'h4};
        rows[4] = '{1'b1, 64'hC,  1'b0, 64'h0};
        rows[5] = '{1'b0, 64'h10, 1'b1, 64'h8};
        rows[6] = '{1'b1, 64'h10, 1'b1, 64'hC};

        // Streaming with always-ready memory, 1-cycle response.
        memLat = 1;
        doReset();
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("row%0d_req_valid", i), sReqV, rows[i].reqV);
            check($sformatf("row%0d_req_addr", i), sReqAddr, rows[i].reqAddr);
            check($sformatf("row%0d_inst_valid", i), sInstV, rows[i].instV);
            if (rows[i].instV) check($sformatf("row%0d_inst_pc", i), sInstPc, rows[i].instPc);
        end

        // Decoder stall: credits cap fetches, nothing lost on resume.
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_credit", (sb.size() <= c_DEPTH), 1'b1);
        end
        check("stall_buffer_full", sb.size(), c_DEPTH);
        bus.inst_ready = 1'b1;
        waitPop(10);
        check("resume_pc0", lastPopPc, 64'h10);
        waitPop(10);
        check("resume_pc1", lastPopPc, 64'h14);
        for (int i = 0; i < 6; i++) tick();

        // Redirect with two fetches in flight.
        memLat = 3;
        doReset();
        tick();
        tick();
        check("inflight_two", memQ.size(), 2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h100;
        tick();
        waitPop(20);
        check("redirect_first_pc", lastPopPc, 64'h100);
        check("redirect_first_word", lastPopInstr, memWord(64'h100));
        for (int i = 0; i < 4; i++) tick();

        // HLT pop stops fetch; later redirect ignored.
        memLat = 1;
        doReset();
        hltAddr  = 64'h8;
        autoHalt = 1'b1;
        for (int i = 0; i < 30 && !expHalted; i++) tick();
        check("halt_reached", expHalted, 1'b1);
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h300;
        tick();
        for (int i = 0; i < 5; i++) tick();

        // Redirect in the same cycle as the HLT pop: redirect wins, misaligned target.
        doReset();
        hltAddr       = 64'h8;
        autoHalt      = 1'b1;
        redirectOnHlt = 1'b1;
        hltRedirect   = 64'h202;
        for (int i = 0; i < 30 && redirectOnHlt; i++) tick();
        check("hlt_redirect_fired", redirectOnHlt, 1'b0);
        autoHalt      = 1'b0;
        bus.req_halt  = 1'b0;
        waitPop(20);
        check("hlt_redirect_pc", lastPopPc, 64'h200);
        check("hlt_redirect_halted", bus.halted, 1'b0);

        // Delivered-instruction counter and mid-stream reset.
        doReset();
        for (int i = 0; i < 5; i++) waitPop(10);
`ifdef FETCH_PERF_EN
        check("perf_five", bus.perf_fetched, 32'd5);
`else
        check("perf_disabled", bus.perf_fetched, 32'd0);
`endif
        tick();
        tick();
        doReset();
        tick();
        check("post_rst_req_valid", sReqV, 1'b1);
        check("post_rst_req_addr", sReqAddr, 64'h0);
        for (int i = 0; i < 4; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
